// File: rtl/axi_wr_slave.sv
// Single-beat AXI write responder: collects AW and W in any order, issues one
// byte-strobed write to a synchronous memory port, then returns B after WRITE_LAT.
module axi_wr_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WLAST,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [3:0]  LAT_M1      = 4'(WRITE_LAT - 1);
  // Window end computed in 33 bits so BASE_ADDR + MEM_SIZE cannot wrap.
  localparam logic [32:0] ADDR_LIMIT  = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};

  state_e      state_q, state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        wlast_q, wlast_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err;

  // Latched request stays constant from MEM through RESP, so the check is combinational.
  assign err = ({1'b0, addr_q} < {1'b0, BASE_ADDR}) ||
               ({1'b0, addr_q} >= ADDR_LIMIT) ||
               !wlast_q;

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = (state_q == S_RESP);
  assign BRESP     = (state_q == S_RESP && err) ? RESP_SLVERR : RESP_OKAY;
  assign mem_wen   = (state_q == S_MEM) && !err && (wstrb_q != 8'h00);
  assign mem_addr  = {addr_q[31:3], 3'b000};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // NOTE: every variable gets its default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wlast_d   = wlast_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (AWVALID && awready_q) begin
          addr_d    = AWADDR;
          aw_held_d = 1'b1;
        end
        if (WVALID && wready_q) begin
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          wlast_d  = WLAST;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) state_d = S_MEM;
      end
      S_MEM: begin
        cnt_d   = LAT_M1;
        state_d = (WRITE_LAT <= 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (BREADY) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered: it reflects where the FSM will be next cycle.
    awready_d = (state_d == S_IDLE) && !aw_held_d;
    wready_d  = (state_d == S_IDLE) && !w_held_d;
  end

  // NOTE: state uses non-blocking assignments; the latched request registers are
  // reset too because the memory port must read all-zero while in reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wlast_q   <= wlast_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: instance "a" uses WRITE_LAT=1, instance "b"
// WRITE_LAT=4; both share AW/W stimulus and have separate BREADY.
module tb_axi_wr_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [31:0] awaddr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        a_bready = 1'b1, b_bready = 1'b1;

  logic        a_awready, a_wready, a_bvalid, a_wen;
  logic [1:0]  a_bresp;
  logic [31:0] a_maddr;
  logic [63:0] a_mwdata;
  logic [7:0]  a_mwstrb;
  logic        b_awready, b_wready, b_bvalid, b_wen;
  logic [1:0]  b_bresp;
  logic [31:0] b_maddr;
  logic [63:0] b_mwdata;
  logic [7:0]  b_mwstrb;

  int total = 0;
  int bad = 0;
  int a_wens = 0;
  int b_wens = 0;

  always #5 ACLK = ~ACLK;

  axi_wr_slave #(.WRITE_LAT(1)) u_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(awvalid), .AWREADY(a_awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(a_wready), .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast),
    .BVALID(a_bvalid), .BREADY(a_bready), .BRESP(a_bresp),
    .mem_wen(a_wen), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wstrb(a_mwstrb)
  );

  axi_wr_slave #(.WRITE_LAT(4)) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(awvalid), .AWREADY(b_awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(b_wready), .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast),
    .BVALID(b_bvalid), .BREADY(b_bready), .BRESP(b_bresp),
    .mem_wen(b_wen), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wstrb(b_mwstrb)
  );

  always @(posedge ACLK) begin
    if (a_wen) a_wens++;
    if (b_wen) b_wens++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_out"}, {a_awready, a_wready, a_bvalid, a_bresp, a_wen, a_maddr, a_mwstrb}, '0);
    chk({tag, "_a_wdata"}, a_mwdata, '0);
    chk({tag, "_b_out"}, {b_awready, b_wready, b_bvalid, b_bresp, b_wen, b_maddr, b_mwstrb}, '0);
    chk({tag, "_b_wdata"}, b_mwdata, '0);
  endtask

  // Presents AW and W together, waits for all readies, ends just after the handshake edge.
  task automatic both_valid(input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic last);
    int n;
    awvalid = 1'b1; awaddr = addr;
    wvalid  = 1'b1; wdata  = data; wstrb = strb; wlast = last;
    n = 0;
    while (!(a_awready && a_wready && b_awready && b_wready) && n < 30) begin
      tick();
      n++;
    end
    chk("hs_wait", n < 30, 1'b1);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic lat1_txn(input string tag, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic last,
                          input logic exp_wen, input logic [31:0] exp_maddr,
                          input logic [1:0] exp_resp);
    int w0;
    w0 = a_wens;
    both_valid(addr, data, strb, last);
    chk({tag, "_wen"}, a_wen, exp_wen);
    if (exp_wen) begin
      chk({tag, "_maddr"}, a_maddr, exp_maddr);
      chk({tag, "_mwdata"}, a_mwdata, data);
      chk({tag, "_mwstrb"}, a_mwstrb, strb);
    end
    chk({tag, "_awrdy_low"}, {a_awready, a_wready}, 2'b00);
    tick();
    chk({tag, "_bvalid"}, a_bvalid, 1'b1);
    chk({tag, "_bresp"}, a_bresp, exp_resp);
    tick();
    chk({tag, "_bvalid_drop"}, a_bvalid, 1'b0);
    chk({tag, "_bresp_clr"}, a_bresp, 2'b00);
    chk({tag, "_rdy_back"}, {a_awready, a_wready}, 2'b11);
    chk({tag, "_wen_count"}, a_wens - w0, exp_wen);
    repeat (5) tick();
  endtask

  initial begin
    int w0;
    int n;
    logic seen;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    ARESETn = 1'b1;
    chk("rst_rel_awrdy_still_low", a_awready, 1'b0);
    tick();
    chk("rst_rel_rdy", {a_awready, a_wready, b_awready, b_wready}, 4'hF);

    // Simultaneous AW/W, legal
    lat1_txn("simul", 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b1,
             1'b1, 32'h8000_0010, 2'b00);

    // W three cycles before AW; W inputs change while not ready and must be ignored
    w0 = a_wens;
    wvalid = 1'b1; wdata = 64'hCAFE_F00D_DEAD_BEEF; wstrb = 8'h0F; wlast = 1'b1;
    tick();
    wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF; wlast = 1'b0;
    chk("wfirst_wrdy_low", a_wready, 1'b0);
    chk("wfirst_awrdy_high", a_awready, 1'b1);
    tick(); tick();
    chk("wfirst_wait_nowen", a_wens - w0, 0);
    wvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h8000_0104;
    tick();
    awvalid = 1'b0;
    chk("wfirst_wen", a_wen, 1'b1);
    chk("wfirst_maddr", a_maddr, 32'h8000_0100);
    chk("wfirst_mwstrb", a_mwstrb, 8'h0F);
    chk("wfirst_mwdata", a_mwdata, 64'hCAFE_F00D_DEAD_BEEF);
    tick();
    chk("wfirst_bvalid", a_bvalid, 1'b1);
    chk("wfirst_bresp", a_bresp, 2'b00);
    tick();
    chk("wfirst_wen_count", a_wens - w0, 1);
    repeat (5) tick();

    // Error and boundary cases
    lat1_txn("below", 32'h7FFF_FFF8, 64'h1, 8'hFF, 1'b1, 1'b0, 32'h0, 2'b10);
    lat1_txn("above", 32'h8800_0000, 64'h2, 8'hFF, 1'b1, 1'b0, 32'h0, 2'b10);
    lat1_txn("nolast", 32'h8000_0040, 64'h3, 8'hFF, 1'b0, 1'b0, 32'h0, 2'b10);
    lat1_txn("nostrb", 32'h8000_0048, 64'h4, 8'h00, 1'b1, 1'b0, 32'h0, 2'b00);
    lat1_txn("base", 32'h8000_0000, 64'hA5A5_0000_FFFF_1234, 8'h81, 1'b1,
             1'b1, 32'h8000_0000, 2'b00);
    lat1_txn("top", 32'h87FF_FFFF, 64'h5555_AAAA_5555_AAAA, 8'hF0, 1'b1,
             1'b1, 32'h87FF_FFF8, 2'b00);

    // WRITE_LAT=4 with B back-pressure
    b_bready = 1'b0;
    both_valid(32'h8000_2008, 64'hFEDC_BA98_7654_3210, 8'h3C, 1'b1);
    chk("lat4_wen", b_wen, 1'b1);
    chk("lat4_maddr", b_maddr, 32'h8000_2008);
    chk("lat4_mwstrb", b_mwstrb, 8'h3C);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("lat4_bvalid_early", b_bvalid, 1'b0);
      chk("lat4_wen_once", b_wen, 1'b0);
    end
    tick();
    chk("lat4_bvalid_t5", b_bvalid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat4_stall_bvalid", b_bvalid, 1'b1);
      chk("lat4_stall_bresp", b_bresp, 2'b00);
      chk("lat4_stall_awrdy", {b_awready, b_wready}, 2'b00);
    end
    b_bready = 1'b1;
    chk("lat4_bvalid_at_hs", b_bvalid, 1'b1);
    tick();
    chk("lat4_bvalid_drop", b_bvalid, 1'b0);
    chk("lat4_rdy_back", {b_awready, b_wready}, 2'b11);
    repeat (3) tick();

    // Reset while instance b is in WAIT
    both_valid(32'h8000_3000, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    tick();
    chk("rstmid_in_wait", b_bvalid, 1'b0);
    ARESETn = 1'b0;
    tick();
    check_all_zero("rstmid");
    tick();
    ARESETn = 1'b1;
    chk("rstmid_rel_awrdy_low", b_awready, 1'b0);
    tick();
    chk("rstmid_rel_rdy", {a_awready, a_wready, b_awready, b_wready}, 4'hF);
    w0 = b_wens;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b_bvalid || a_bvalid) seen = 1'b1;
    end
    chk("rstmid_no_bvalid", seen, 1'b0);
    chk("rstmid_no_wen", b_wens - w0, 0);

    // Next transaction after reset completes normally
    both_valid(32'h8000_3010, 64'h9999_8888_7777_6666, 8'h0F, 1'b1);
    chk("after_wen", b_wen, 1'b1);
    chk("after_maddr", b_maddr, 32'h8000_3010);
    n = 0;
    while (!b_bvalid && n < 10) begin
      tick();
      n++;
    end
    chk("after_bvalid_latency", n, 4);
    chk("after_bresp", b_bresp, 2'b00);
    tick();
    chk("after_bvalid_drop", b_bvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
